// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared types and constants for the ALU op sequencer:
//               FSM state encoding, ALU opcodes and instruction field layout.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

  localparam int DATA_W  = 4;
  localparam int IDX_W   = 2;
  localparam int INSTR_W = 10;

  // Instruction field layout: [9] ld, [8:6] op, [5:4] rd, [3:2] rs, [1:0] rt
  localparam int LD_BIT  = 9;
  localparam int OP_LSB  = 6;
  localparam int OP_W    = 3;
  localparam int RD_LSB  = 4;
  localparam int RS_LSB  = 2;
  localparam int RT_LSB  = 0;
  localparam int IMM_LSB = 0;

  localparam logic [OP_W-1:0] OP_SUB  = 3'd0;
  localparam logic [OP_W-1:0] OP_ADD  = 3'd1;
  localparam logic [OP_W-1:0] OP_OR   = 3'd2;
  localparam logic [OP_W-1:0] OP_AND  = 3'd3;
  localparam logic [OP_W-1:0] OP_RSH  = 3'd4;
  localparam logic [OP_W-1:0] OP_ROTL = 3'd5;
  localparam logic [OP_W-1:0] OP_LT   = 3'd6;
  localparam logic [OP_W-1:0] OP_EQ   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPER = 2'd1,
    WB   = 2'd2,
    HOLD = 2'd3
  } seq_state_e;

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/alu_seq_regfile.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_regfile
// Description : NREG x W register file, two asynchronous read ports, one
//               synchronous write port, asynchronous active-low clear.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_regfile #(
  parameter  int NREG = 4,
  parameter  int W    = 4,
  localparam int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr_a,
  input  logic [AW-1:0] i_raddr_b,
  output logic [W-1:0]  o_rdata_a,
  output logic [W-1:0]  o_rdata_b
);

  logic [W-1:0] r_mem [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule : alu_seq_regfile
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer
// Description : Fetches operands from a 4x4 register file, drives an external
//               combinational ALU, writes the result back and presents it on
//               a valid/ready output. Optional macro SEQ_OPCOUNT_EN adds a
//               result-handshake counter (op_count) with clear (cnt_clr).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NREG = 4,
  parameter int W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic [W-1:0]       alu_rs,
  output logic [W-1:0]       alu_rt,
  output logic [OP_W-1:0]    alu_sel,
  input  logic [W-1:0]       alu_rd,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [W-1:0]       res_data,
  output logic [IDX_W-1:0]   res_idx
`ifdef SEQ_OPCOUNT_EN
  ,
  input  logic               cnt_clr,
  output logic [7:0]         op_count
`endif
);

  seq_state_e       r_state;
  seq_state_e       w_next_state;

  logic             w_ld;
  logic [OP_W-1:0]  w_op;
  logic [IDX_W-1:0] w_rd;
  logic [IDX_W-1:0] w_rs;
  logic [IDX_W-1:0] w_rt;
  logic [W-1:0]     w_imm;
  logic             w_accept;
  logic             w_wr_en;
  logic [W-1:0]     w_rs_val;
  logic [W-1:0]     w_rt_val;

  logic [W-1:0]     r_alu_rs;
  logic [W-1:0]     r_alu_rt;
  logic [OP_W-1:0]  r_alu_sel;
  logic [W-1:0]     r_result;
  logic [IDX_W-1:0] r_dest;
  logic [W-1:0]     r_res_data;
  logic [IDX_W-1:0] r_res_idx;

  assign w_ld     = in_instr[LD_BIT];
  assign w_op     = in_instr[OP_LSB +: OP_W];
  assign w_rd     = in_instr[RD_LSB +: IDX_W];
  assign w_rs     = in_instr[RS_LSB +: IDX_W];
  assign w_rt     = in_instr[RT_LSB +: IDX_W];
  assign w_imm    = in_instr[IMM_LSB +: W];
  assign w_accept = in_valid && (r_state == IDLE);
  assign w_wr_en  = (r_state == WB);

  alu_seq_regfile #(
    .NREG (NREG),
    .W    (W)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (w_wr_en),
    .i_waddr   (r_dest),
    .i_wdata   (r_result),
    .i_raddr_a (w_rs),
    .i_raddr_b (w_rt),
    .o_rdata_a (w_rs_val),
    .o_rdata_b (w_rt_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    res_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next_state = w_ld ? WB : OPER;
        end
      end
      OPER: w_next_state = WB;
      WB:   w_next_state = HOLD;
      HOLD: begin
        res_valid = 1'b1;
        if (res_ready) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // ALU operand/select registers only move on accept, so they hold steady
  // through OPER and keep their last value afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_rs   <= '0;
      r_alu_rt   <= '0;
      r_alu_sel  <= '0;
      r_result   <= '0;
      r_dest     <= '0;
      r_res_data <= '0;
      r_res_idx  <= '0;
    end else begin
      if (w_accept) begin
        r_dest <= w_rd;
        if (w_ld) begin
          r_result <= w_imm;
        end else begin
          r_alu_rs  <= w_rs_val;
          r_alu_rt  <= w_rt_val;
          r_alu_sel <= w_op;
        end
      end
      if (r_state == OPER) begin
        r_result <= alu_rd;
      end
      if (r_state == WB) begin
        r_res_data <= r_result;
        r_res_idx  <= r_dest;
      end
    end
  end

  assign alu_rs   = r_alu_rs;
  assign alu_rt   = r_alu_rt;
  assign alu_sel  = r_alu_sel;
  assign res_data = r_res_data;
  assign res_idx  = r_res_idx;

`ifdef SEQ_OPCOUNT_EN
  logic [7:0] r_op_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count <= '0;
    end else if (cnt_clr) begin
      r_op_count <= '0;
    end else if (res_valid && res_ready) begin
      r_op_count <= r_op_count + 8'd1;
    end
  end

  assign op_count = r_op_count;
`endif

endmodule : alu_op_sequencer
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_op_sequencer
// Description : Self-checking bench for alu_op_sequencer with a behavioural
//               ALU, vector table and result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_instr;
  logic [3:0] alu_rs;
  logic [3:0] alu_rt;
  logic [2:0] alu_sel;
  logic [3:0] alu_rd;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic [1:0] res_idx;
`ifdef SEQ_OPCOUNT_EN
  logic       cnt_clr;
  logic [7:0] op_count;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  logic [5:0] exp_q[$];

  typedef struct {
    logic [9:0] instr;
    logic [3:0] d;
    logic [1:0] idx;
  } vec_t;
  vec_t vecs[15];

  alu_op_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .alu_rs    (alu_rs),
    .alu_rt    (alu_rt),
    .alu_sel   (alu_sel),
    .alu_rd    (alu_rd),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_idx   (res_idx)
`ifdef SEQ_OPCOUNT_EN
    ,
    .cnt_clr   (cnt_clr),
    .op_count  (op_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External 4-bit ALU
  always_comb begin
    case (alu_sel)
      3'd0:    alu_rd = alu_rs - alu_rt;
      3'd1:    alu_rd = alu_rs + alu_rt;
      3'd2:    alu_rd = alu_rs | alu_rt;
      3'd3:    alu_rd = alu_rs & alu_rt;
      3'd4:    alu_rd = alu_rs >> alu_rt;
      3'd5:    alu_rd = {alu_rs[2:0], alu_rs[3]};
      3'd6:    alu_rd = {3'b000, (alu_rs < alu_rt)};
      default: alu_rd = {3'b000, (alu_rs == alu_rt)};
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] mk_op(input logic [2:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs, input logic [1:0] rt);
    return {1'b0, op, rd, rs, rt};
  endfunction

  function automatic logic [9:0] mk_ld(input logic [1:0] rd, input logic [3:0] imm);
    return {1'b1, 3'b000, rd, imm};
  endfunction

  // Scoreboard: one pop per result handshake
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", {26'd0, res_idx, res_data}, 32'hFFFF_FFFF);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        chk("res_data", res_data, e[3:0]);
        chk("res_idx", res_idx, e[5:4]);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle res_valid rises.
  task automatic issue(input logic [9:0] ins, input logic [3:0] d, input logic [1:0] idx);
    int  lat;
    bit  got;
    bit  rdy;
    in_valid = 1'b1;
    in_instr = ins;
    rdy = 1'b0;
    for (int g = 0; g < 20; g++) begin
      if (in_ready) begin
        rdy = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!rdy) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back({idx, d});
    @(posedge clk); #1;
    in_valid = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (res_valid) begin
        got = 1'b1;
        lat = k;
        break;
      end
    end
    chk("latency", got ? lat : 99, ins[9] ? 1 : 2);
  endtask

  task automatic drain();
    for (int g = 0; g < 20 && exp_q.size() != 0; g++) begin
      @(posedge clk); #1;
    end
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{mk_op(3'd1, 2'd0, 2'd0, 2'd0), 4'd0,  2'd0};
    vecs[1]  = '{mk_ld(2'd1, 4'd5),             4'd5,  2'd1};
    vecs[2]  = '{mk_ld(2'd2, 4'd3),             4'd3,  2'd2};
    vecs[3]  = '{mk_op(3'd0, 2'd3, 2'd1, 2'd2), 4'd2,  2'd3};
    vecs[4]  = '{mk_op(3'd1, 2'd0, 2'd3, 2'd1), 4'd7,  2'd0};
    vecs[5]  = '{mk_op(3'd6, 2'd3, 2'd1, 2'd2), 4'd0,  2'd3};
    vecs[6]  = '{mk_op(3'd7, 2'd3, 2'd2, 2'd2), 4'd1,  2'd3};
    vecs[7]  = '{mk_op(3'd2, 2'd1, 2'd1, 2'd0), 4'd7,  2'd1};
    vecs[8]  = '{mk_op(3'd3, 2'd2, 2'd1, 2'd2), 4'd3,  2'd2};
    vecs[9]  = '{mk_op(3'd4, 2'd0, 2'd1, 2'd3), 4'd3,  2'd0};
    vecs[10] = '{mk_op(3'd5, 2'd3, 2'd1, 2'd0), 4'd14, 2'd3};
    vecs[11] = '{mk_op(3'd0, 2'd1, 2'd2, 2'd3), 4'd5,  2'd1};
    vecs[12] = '{mk_ld(2'd2, 4'd15),            4'd15, 2'd2};
    vecs[13] = '{mk_op(3'd1, 2'd0, 2'd2, 2'd2), 4'd14, 2'd0};
    vecs[14] = '{mk_op(3'd6, 2'd3, 2'd1, 2'd2), 4'd1,  2'd3};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    res_ready = 1'b1;
`ifdef SEQ_OPCOUNT_EN
    cnt_clr   = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_alu_sel", alu_sel, 0);
    chk("rst_alu_rs", alu_rs, 0);
    chk("rst_res_data", res_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      issue(vecs[i].instr, vecs[i].d, vecs[i].idx);
    end
    drain();

    // Backpressure with a held instruction
    res_ready = 1'b0;
    issue(mk_ld(2'd1, 4'd9), 4'd9, 2'd1);
    in_valid = 1'b1;
    in_instr = mk_ld(2'd2, 4'd4);
    exp_q.push_back({2'd2, 4'd4});
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_res_valid", res_valid, 1);
      chk("bp_res_data", res_data, 9);
      chk("bp_in_ready", in_ready, 0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_res_valid", res_valid, 0);
    @(posedge clk); #1;
    chk("bp_accepted", in_ready, 0);
    in_valid = 1'b0;
    drain();
    repeat (2) @(posedge clk);
    #1;

    // Reset during OPER of ADD R2 = R1 + R1
    in_valid = 1'b1;
    in_instr = mk_op(3'd1, 2'd2, 2'd1, 2'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("oper_alu_sel", alu_sel, 1);
    chk("oper_alu_rs", alu_rs, 9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_alu_sel", alu_sel, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(mk_op(3'd1, 2'd0, 2'd2, 2'd2), 4'd0, 2'd0);
    issue(mk_op(3'd1, 2'd1, 2'd1, 2'd1), 4'd0, 2'd1);
    drain();

`ifdef SEQ_OPCOUNT_EN
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk("cnt_cleared", op_count, 0);
    for (int i = 0; i < 258; i++) begin
      issue(mk_ld(2'd3, i[3:0]), i[3:0], 2'd3);
    end
    @(posedge clk); #1;
    chk("cnt_wrap", op_count, 2);
    res_ready = 1'b0;
    issue(mk_ld(2'd0, 4'd6), 4'd6, 2'd0);
    res_ready = 1'b1;
    cnt_clr   = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk("cnt_clr_priority", op_count, 0);
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_alu_op_sequencer
`default_nettype wire
